// File: rtl/bram_rnw1_clr.sv
// bram_rnw1_clr: block RAM with NRD registered read ports and one
// byte-enabled write port. After every reset an INIT/RUN state machine
// sweeps the whole physical array (DPT_2N words) to zero; o_init_done
// rises when the sweep finishes and the RAM becomes usable.
//
// Optional feature macro: BRAM_WFWD_EN
//   defined   -> same-address read/write on one edge returns the merged
//                (byte-enable-forwarded) word on each read port.
//   undefined -> read-first: the read returns the pre-write contents.
//
// Read handshake: o_rvalid[k] is high for exactly one cycle per read
// accepted on port k (i_rden[k]=1 in RUN) and qualifies o_rdata[k] in
// that cycle; there is no backpressure. When o_rvalid[k] is low,
// o_rdata[k] simply holds its last value.
module bram_rnw1_clr #(
  parameter  int DTW    = 32,
  parameter  int DPT    = 32,
  parameter  int NRD    = 2,
  localparam int ADW    = $clog2(DPT),
  localparam int DPT_2N = 2 ** ADW,
  localparam int NBE    = DTW / 8
) (
  input  logic               clk,
  input  logic               aresetn,
  output logic               o_init_done,
  input  logic               i_wren,
  input  logic [ADW-1:0]     i_waddr,
  input  logic [NBE-1:0]     i_wbe,
  input  logic [DTW-1:0]     i_wdata,
  input  logic [NRD-1:0]     i_rden,
  input  logic [NRD*ADW-1:0] i_raddr,
  output logic [NRD*DTW-1:0] o_rdata,
  output logic [NRD-1:0]     o_rvalid,
  output logic               o_dbg_state
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ADW-1:0]     cnt_q, cnt_d;
  logic               sweep_we;
  logic               run;
  logic [NRD*DTW-1:0] rdata_q, rdata_d;
  logic [NRD-1:0]     rvalid_q, rvalid_d;
  logic [ADW-1:0]     rd_addr;
  logic [DTW-1:0]     rd_word;

  (* ram_style = "block" *) logic [DTW-1:0] mem [DPT_2N];

  // State and sweep-counter registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: INIT clears one word per edge, RUN is terminal.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == ADW'(DPT_2N - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign run         = (state_q == ST_RUN);
  assign o_init_done = run;
  assign o_dbg_state = state_q;

  // Array write port: zero sweep in INIT, byte-enabled user write in RUN.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt_q] <= '0;
    end else if (run && i_wren) begin
      for (int b = 0; b < NBE; b++) begin
        if (i_wbe[b]) begin
          mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read-port next values: fetch (optionally forwarded) word per enabled port.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = '0;
    rd_addr  = '0;
    rd_word  = '0;
    if (run) begin
      for (int k = 0; k < NRD; k++) begin
        if (i_rden[k]) begin
          rd_addr = i_raddr[k*ADW +: ADW];
          rd_word = mem[rd_addr];
`ifdef BRAM_WFWD_EN
          if (i_wren && (i_waddr == rd_addr)) begin
            for (int b = 0; b < NBE; b++) begin
              if (i_wbe[b]) begin
                rd_word[8*b +: 8] = i_wdata[8*b +: 8];
              end
            end
          end
`endif
          rdata_d[k*DTW +: DTW] = rd_word;
          rvalid_d[k]           = 1'b1;
        end
      end
    end
  end

  // Read output registers; reset so nothing leaks out before the sweep.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;

endmodule

// File: tb/tb_bram_rnw1_clr.sv
// Bench for bram_rnw1_clr: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_bram_rnw1_clr;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn = 1'b0;
  logic b_rstn  = 1'b0;

  // ---------------- main DUT (DPT=32, NRD=2) ----------------
  logic        o_init_done;
  logic        i_wren  = 1'b0;
  logic [4:0]  i_waddr = '0;
  logic [3:0]  i_wbe   = '0;
  logic [31:0] i_wdata = '0;
  logic [1:0]  i_rden  = '0;
  logic [9:0]  i_raddr = '0;
  logic [63:0] o_rdata;
  logic [1:0]  o_rvalid;
  logic        o_dbg_state;

  bram_rnw1_clr #(.DTW(32), .DPT(32), .NRD(2)) dut (
    .clk(clk), .aresetn(aresetn), .o_init_done(o_init_done),
    .i_wren(i_wren), .i_waddr(i_waddr), .i_wbe(i_wbe), .i_wdata(i_wdata),
    .i_rden(i_rden), .i_raddr(i_raddr), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_dbg_state(o_dbg_state)
  );

  // ---------------- second DUT (DPT=20 -> 32 physical, NRD=1) ----------------
  logic        b_init_done;
  logic        b_wren  = 1'b0;
  logic [4:0]  b_waddr = '0;
  logic [3:0]  b_wbe   = '0;
  logic [31:0] b_wdata = '0;
  logic [0:0]  b_rden  = '0;
  logic [4:0]  b_raddr = '0;
  logic [31:0] b_rdata;
  logic [0:0]  b_rvalid;
  logic        b_dbg_state;

  bram_rnw1_clr #(.DTW(32), .DPT(20), .NRD(1)) dut_np (
    .clk(clk), .aresetn(b_rstn), .o_init_done(b_init_done),
    .i_wren(b_wren), .i_waddr(b_waddr), .i_wbe(b_wbe), .i_wdata(b_wdata),
    .i_rden(b_rden), .i_raddr(b_raddr), .o_rdata(b_rdata),
    .o_rvalid(b_rvalid), .o_dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main DUT ----------------
  // The RAM is a plain word array; after reset the first 32 edges only
  // clear memory, after that each edge performs reads then the write.
  logic [31:0] m_mem [32];
  int          m_edges = 0;
  logic        m_done  = 1'b0;
  logic [1:0]  m_rv    = '0;
  logic [63:0] m_rd    = '0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge aresetn);
      if (!aresetn) begin
        m_edges = 0;
        m_done  = 1'b0;
        m_rv    = '0;
        m_rd    = '0;
      end else if (m_edges < 32) begin
        m_mem[m_edges] = '0;
        m_edges++;
        m_done = (m_edges == 32);
        m_rv   = '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          logic [4:0]  a;
          logic [31:0] w;
          m_rv[k] = i_rden[k];
          if (i_rden[k]) begin
            a = i_raddr[k*5 +: 5];
            w = m_mem[a];
`ifdef BRAM_WFWD_EN
            if (i_wren && i_waddr == a) w = merge(w, i_wdata, i_wbe);
`endif
            m_rd[k*32 +: 32] = w;
          end
        end
        if (i_wren) m_mem[i_waddr] = merge(m_mem[i_waddr], i_wdata, i_wbe);
      end
    end
  end

  // Compare process: every cycle, just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        check("model_init_done", 64'(o_init_done), 64'(m_done));
        check("model_rvalid", 64'(o_rvalid), 64'(m_rv));
        check("model_rdata", o_rdata, m_rd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [3:0] be,
                     input logic [31:0] wd, input logic [1:0] re,
                     input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    i_wren  = we;
    i_waddr = wa;
    i_wbe   = be;
    i_wdata = wd;
    i_rden  = re;
    i_raddr = {a1, a0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 2'b00, '0, '0);
  endtask

  task automatic b_cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra);
    @(negedge clk);
    b_wren  = we;
    b_waddr = wa;
    b_wbe   = 4'hF;
    b_wdata = wd;
    b_rden  = re;
    b_raddr = ra;
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] exp_rdw;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", 64'(o_init_done), 64'd0);
    check("rst_rvalid", 64'(o_rvalid), 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    cmp_en = 1'b1;

    // Sweep with write/read attempts that must be ignored.
    @(negedge clk);
    aresetn = 1'b1;
    i_wren  = 1'b1;
    i_waddr = 5'd2;
    i_wbe   = 4'hF;
    i_wdata = 32'hFFFF_FFFF;
    i_rden  = 2'b11;
    i_raddr = {5'd2, 5'd2};
    n = 0;
    while (!o_init_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!o_init_done) check("init_rvalid", 64'(o_rvalid), 64'd0);
    end
    check("init_edges", 64'(n), 64'd32);
    idle();

    // Every address reads zero after the sweep.
    for (int a = 0; a < 32; a++) begin
      cyc(1'b0, '0, '0, '0, 2'b11, 5'(a), 5'(31 - a));
      check("sweep_zero_rdata", o_rdata, 64'd0);
      check("sweep_zero_rvalid", 64'(o_rvalid), 64'd3);
    end
    cyc(1'b0, '0, '0, '0, 2'b01, 5'd2, 5'd0);
    check("init_write_ignored", 64'(o_rdata[31:0]), 64'd0);

    // Byte-enable write.
    cyc(1'b1, 5'd5, 4'hF, 32'hDEAD_BEEF, 2'b00, '0, '0);
    cyc(1'b1, 5'd5, 4'b0101, 32'h1122_3344, 2'b00, '0, '0);
    cyc(1'b0, '0, '0, '0, 2'b01, 5'd5, '0);
    check("byte_enable", 64'(o_rdata[31:0]), 64'h0000_0000_DE22_BE44);
    cyc(1'b1, 5'd5, 4'h0, 32'hFFFF_FFFF, 2'b00, '0, '0);
    cyc(1'b0, '0, '0, '0, 2'b10, '0, 5'd5);
    check("wbe_zero_noop", 64'(o_rdata[63:32]), 64'h0000_0000_DE22_BE44);

    // Multi-port read and hold.
    cyc(1'b1, 5'd3, 4'hF, 32'h0000_000A, 2'b00, '0, '0);
    cyc(1'b1, 5'd7, 4'hF, 32'h0000_000B, 2'b00, '0, '0);
    cyc(1'b0, '0, '0, '0, 2'b11, 5'd3, 5'd7);
    check("mp_rdata", o_rdata, 64'h0000_000B_0000_000A);
    check("mp_rvalid", 64'(o_rvalid), 64'd3);
    idle();
    check("hold_rdata", o_rdata, 64'h0000_000B_0000_000A);
    check("hold_rvalid", 64'(o_rvalid), 64'd0);

    // Read-during-write on the same address.
    cyc(1'b1, 5'd9, 4'hF, 32'h0000_0001, 2'b00, '0, '0);
    cyc(1'b1, 5'd9, 4'hF, 32'h0000_0002, 2'b11, 5'd9, 5'd9);
`ifdef BRAM_WFWD_EN
    exp_rdw = 32'h0000_0002;
`else
    exp_rdw = 32'h0000_0001;
`endif
    check("rdw_port0", 64'(o_rdata[31:0]), 64'(exp_rdw));
    check("rdw_port1", 64'(o_rdata[63:32]), 64'(exp_rdw));
    cyc(1'b0, '0, '0, '0, 2'b01, 5'd9, '0);
    check("rdw_after", 64'(o_rdata[31:0]), 64'h2);

    // Randomized traffic over a narrow address window for collisions.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom),
          $urandom, 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle();

    // Reset mid-operation on the main DUT; model follows.
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    check("midrst_rvalid", 64'(o_rvalid), 64'd0);
    check("midrst_done", 64'(o_init_done), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      cyc(1'b0, '0, '0, '0, 2'b11, 5'(a), 5'(a + 8));
      check("rerst_zero", o_rdata, 64'd0);
    end
    cmp_en = 1'b0;

    // Non-power-of-two depth with reset mid-sweep.
    @(negedge clk);
    b_rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    b_rstn = 1'b0;
    #1;
    check("np_rst_done", 64'(b_init_done), 64'd0);
    check("np_rst_rvalid", 64'(b_rvalid), 64'd0);
    check("np_rst_rdata", 64'(b_rdata), 64'd0);
    @(negedge clk);
    b_rstn = 1'b1;
    n = 0;
    while (!b_init_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("np_init_edges", 64'(n), 64'd32);
    b_cyc(1'b0, '0, '0, 1'b1, 5'd25);
    check("np_addr25_zero", 64'(b_rdata), 64'd0);
    check("np_addr25_rvalid", 64'(b_rvalid), 64'd1);
    b_cyc(1'b1, 5'd25, 32'h5A5A_1234, 1'b0, '0);
    b_cyc(1'b0, '0, '0, 1'b1, 5'd25);
    check("np_addr25_rw", 64'(b_rdata), 64'h5A5A_1234);
    b_cyc(1'b0, '0, '0, 1'b0, '0);
    check("np_hold", 64'(b_rdata), 64'h5A5A_1234);
    check("np_hold_rvalid", 64'(b_rvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bram_rnw1_clr.md
Name: bram_rnw1_clr

Overview:
Parametrised block RAM with NRD synchronous read ports and one byte-enabled synchronous write port. It is the successor to the fixed 2-read/1-write register-file RAM in the pqr5 core. After every reset an internal state machine sweeps the array to zero, so the register file and scratch RAMs come up deterministic without a software clear loop. Per-port read-valid flags let the consumer track returned data.

Parameters:
DTW, 32, data width in bits; must be a multiple of 8.
DPT, 32, logical depth.
NRD, 2, number of read ports; 1..4.
ADW (local), $clog2(DPT), address width.
DPT_2N (local), 2**ADW, physical depth rounded up for BRAM mapping.
NBE (local), DTW/8, byte lanes.

Ports:
clk  in  1  clock; all logic on the rising edge.
aresetn  in  1  asynchronous active-low reset.
o_init_done  out  1  high once the zero-sweep is complete; RAM is usable.
i_wren  in  1  write enable.
i_waddr  in  ADW  write address.
i_wbe  in  NBE  byte enables; bit b covers data[8b+7:8b].
i_wdata  in  DTW  write data.
i_rden  in  NRD  per-port read enable.
i_raddr  in  NRD*ADW  packed read addresses; port k at [k*ADW +: ADW].
o_rdata  out  NRD*DTW  packed read data; port k at [k*DTW +: DTW].
o_rvalid  out  NRD  per-port valid, aligned with o_rdata.

Behaviour:
- Reset values (asynchronous, while aresetn=0):
  - FSM=INIT, sweep counter=0, o_init_done=0, o_rvalid=0, o_rdata=0.
  - Array contents are not reset directly; they are cleared by the sweep.
- FSM states: INIT, RUN.
  - INIT: each rising edge writes all-zero to ram[cnt] and increments cnt.
  - On the edge that writes address DPT_2N-1: go to RUN, set o_init_done=1.
  - o_init_done therefore rises on the DPT_2N-th rising edge after aresetn deasserts.
  - RUN: stays in RUN until the next reset.
- In INIT:
  - i_wren, i_rden and addresses are ignored.
  - o_rvalid stays 0 and o_rdata holds 0.
- Write (RUN only):
  - When i_wren=1, for each b with i_wbe[b]=1, ram[i_waddr] byte b <= i_wdata byte b.
  - Other bytes are unchanged.
  - i_wren=1 with i_wbe=0 is a no-op.
- Read (RUN only), latency 1:
  - If i_rden[k]=1 at edge N, o_rdata[k] shows ram[i_raddr[k]] and o_rvalid[k]=1 after edge N.
  - If i_rden[k]=0, o_rdata[k] holds its last value and o_rvalid[k]=0 on the next cycle.
  - Ports are independent; any number of ports may read the same address in the same cycle.
- Read-during-write, same address, same edge (RUN): read-first. o_rdata returns the pre-write contents (default build).
- Addresses at or above DPT but below DPT_2N are legal physical locations: they are cleared by the sweep and readable/writable. No range error is flagged.
- Reset mid-operation (including mid-sweep):
  - Outputs return to reset values immediately.
  - The sweep restarts from address 0 after deassertion.
  - Writes in flight at assertion are not guaranteed.
- Synthesis: the array carries the block-RAM style attribute. Output registers are reset; the array is not.

Optional Feature:
Macro BRAM_WFWD_EN.
- Defined: write-to-read forwarding. For a same-address read and write on the same edge, o_rdata[k] returns the merged word:
  - i_wdata bytes where i_wbe=1;
  - old RAM bytes where i_wbe=0.
  The mux is per port, so the pipeline needs no register-file bypass. It infers extra LUTs outside the BRAM.
- Undefined: read-first behaviour as in Behaviour; no forwarding logic is present.

Test Plan:
1. Init sweep (DPT=32, NRD=2): pulse aresetn low, release, read all 32 addresses after o_init_done -> o_init_done rises on edge 32; every read returns 0x00000000 with o_rvalid=1 one cycle after i_rden.
2. Byte-enable write: write 0xDEADBEEF to address 5 with wbe=4'hF, then 0x11223344 with wbe=4'b0101 -> port0 read of address 5 returns 0xDE22BE44.
3. Multi-port read with hold: preload addresses 3 and 7 with 0xA and 0xB; read port0@3 and port1@7 in the same cycle; then drop i_rden -> next cycle 0xA/0xB with o_rvalid=2'b11; following cycle data held, o_rvalid=2'b00.
4. Read-during-write: address 9 holds 0x1; write 0x2 (wbe=F) and read address 9 on the same edge -> 0x1 without BRAM_WFWD_EN, 0x2 with it; a subsequent read returns 0x2 in both builds.
5. Access during INIT: assert i_wren (addr 2, 0xFFFFFFFF) and i_rden during the sweep -> o_rvalid stays 0; after done, address 2 reads 0.
6. Mid-sweep reset plus non-power-of-two depth: set DPT=20 (DPT_2N=32), assert aresetn at sweep count 10 -> outputs are 0 at once; o_init_done rises 32 edges after release; address 25 reads 0.
